// File: rtl/seed_pkg.sv
// Shared types and defaults for the SEED round sequencing controller.
package seed_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_LOAD,
    S_ROUND,
    S_DONE
  } state_t;

  localparam int unsigned DEF_NUM_ROUNDS    = 16;
  localparam int unsigned DEF_CYC_PER_ROUND = 2;
  localparam int unsigned IDX_W             = 4;
  localparam int unsigned RND_W             = 5;
  localparam int unsigned PH_W              = 2;

endpackage

// File: rtl/seed_round_ctrl_phase.sv
// Intra-round phase counter: counts 0..CYC_PER_ROUND-1 while enabled.
module seed_phase_cnt
  import seed_pkg::*;
#(
  parameter int unsigned CYC_PER_ROUND = DEF_CYC_PER_ROUND
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            clr,
  output logic [PH_W-1:0] phase,
  output logic            wrap
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYC_PER_ROUND - 1);

  assign wrap = (phase == PH_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= wrap ? '0 : phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/seed_round_ctrl.sv
// Sequences key schedule start, block load and per-round enables for a SEED core.
module seed_round_ctrl
  import seed_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS    = DEF_NUM_ROUNDS,
  parameter int unsigned CYC_PER_ROUND = DEF_CYC_PER_ROUND
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             decrypt,
  input  logic             key_done,
  output logic             ks_start,
  output logic             load_blk,
  output logic             rnd_en,
  output logic [IDX_W-1:0] round,
  output logic [IDX_W-1:0] sk_idx,
  output logic             last_rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CYC_PER_ROUND - 1);
  localparam logic             ONE_CYC  = (CYC_PER_ROUND == 1);

  state_t           state_q;
  logic [RND_W-1:0] round_q;
  logic             mode_q;
  logic [PH_W-1:0]  phase;
  logic             wrap;

  seed_phase_cnt #(.CYC_PER_ROUND(CYC_PER_ROUND)) u_phase (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q == S_ROUND),
    .clr     (state_q == S_LOAD),
    .phase   (phase),
    .wrap    (wrap)
  );

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign round    = round_q[IDX_W-1:0];
  assign last_rnd = (state_q == S_ROUND) && (round_q == LAST_RND);
  assign sk_idx   = mode_q ? (LAST_IDX - round) : round;

  // rnd_en is registered, so it is set one cycle ahead from the phase the counter will reach next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      round_q   <= '0;
      mode_q    <= 1'b0;
      ks_start  <= 1'b0;
      load_blk  <= 1'b0;
      rnd_en    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      ks_start <= 1'b0;
      load_blk <= 1'b0;
      rnd_en   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mode_q   <= decrypt;
            ks_start <= 1'b1;
            state_q  <= S_KEY;
          end
        end
        S_KEY: begin
          if (key_done) begin
            load_blk <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          round_q <= '0;
          rnd_en  <= ONE_CYC;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          if (wrap) begin
            if (round_q == LAST_RND) begin
              out_valid <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              round_q <= round_q + RND_W'(1);
              rnd_en  <= ONE_CYC;
            end
          end else begin
            rnd_en <= (phase + PH_W'(1) == PH_LAST);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seed_round_ctrl.md
SEED_ROUND_CTRL -- requirements
Module: seed_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 16: rounds per block; legal range 2..16.
REQ-002 Parameter CYC_PER_ROUND, default 2: clock cycles per round; legal range 1..4.
REQ-003 clk  in  1  internal 100 MHz clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  plaintext/ciphertext and mode are presented for a new block.
REQ-006 in_ready  out  1  controller accepts a block; high only in IDLE.
REQ-007 decrypt  in  1  mode, sampled on acceptance: 0 = encrypt, 1 = decrypt.
REQ-008 key_done  in  1  level: key schedule has produced all subkeys.
REQ-009 ks_start  out  1  one-cycle pulse that starts the key schedule.
REQ-010 load_blk  out  1  one-cycle pulse that loads the input block into the datapath registers.
REQ-011 rnd_en  out  1  pulse on the last cycle of each round; the datapath updates L/R on it.
REQ-012 round  out  4  current round index, 0..NUM_ROUNDS-1.
REQ-013 sk_idx  out  4  subkey index: round when encrypting, NUM_ROUNDS-1-round when decrypting.
REQ-014 last_rnd  out  1  high while round == NUM_ROUNDS-1 (no L/R swap).
REQ-015 out_valid  out  1  result is valid; held until out_ready.
REQ-016 out_ready  in  1  consumer takes the result.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM states shall be IDLE, KEY, LOAD, ROUND and DONE.
REQ-019 IDLE: in_ready=1; in_valid=1 -> latch decrypt, assert ks_start for 1 cycle, go to KEY.
REQ-020 KEY: wait for key_done=1, then go to LOAD; key_done already high on KEY entry -> leave after 1 cycle.
REQ-021 LOAD: load_blk=1 for exactly 1 cycle; round<=0, phase counter<=0; go to ROUND.
REQ-022 ROUND: the phase counter shall count 0..CYC_PER_ROUND-1; rnd_en=1 when phase==CYC_PER_ROUND-1.
REQ-023 On rnd_en with round<NUM_ROUNDS-1: round increments and phase wraps to 0.
REQ-024 On rnd_en with round==NUM_ROUNDS-1: go to DONE; round holds at NUM_ROUNDS-1.
REQ-025 Each block's latency from acceptance to out_valid shall be 1 + key-wait cycles + 1 + NUM_ROUNDS*CYC_PER_ROUND cycles (35 with default parameters and key_done already high).
REQ-026 DONE: out_valid=1; when out_ready=1 -> go to IDLE, with out_valid low on the next cycle.
REQ-027 out_ready=1 outside DONE shall be ignored; in_valid outside IDLE shall be ignored, with no queuing.
REQ-028 key_done falling during ROUND shall not affect sequencing.
REQ-029 The internal round counter shall be 5 bits wide, so that round never wraps past NUM_ROUNDS-1.
REQ-030 sk_idx shall be combinational from round and the latched mode.
REQ-031 ks_start, load_blk and rnd_en shall be registered, glitch-free outputs.

Reset
REQ-032 reset_n low shall force IDLE asynchronously: round=0, phase=0, latched mode=0, and ks_start, load_blk, rnd_en, out_valid and busy all 0.
REQ-033 After reset release, in_ready=1 combinationally from IDLE.
REQ-034 Reset asserted mid-block shall abandon the block with no out_valid; the first accepted block after release shall behave as from cold reset.

Structure
REQ-035 A shared package seed_pkg shall hold the state enum, the default NUM_ROUNDS and CYC_PER_ROUND, and the round/subkey index width (4).
REQ-036 The phase counter shall be a sub-module seed_phase_cnt: inputs en and clr; outputs phase and wrap.
REQ-037 The datapath, F-function and key schedule shall be outside this block.

Verification
REQ-038 Encrypt with key_done high and out_ready high -> ks_start at cycle 1, load_blk at 2, rnd_en at cycles 4,6,...,34, out_valid at 35, round 0..15, sk_idx == round.
REQ-039 Decrypt, otherwise identical -> sk_idx sequence 15,14,...,0; last_rnd high only during round 15.
REQ-040 key_done held low for 10 cycles after ks_start -> FSM stays in KEY, and load_blk occurs 1 cycle after key_done rises.
REQ-041 out_ready low for 5 cycles in DONE -> out_valid held for those 5 cycles; in_valid pulses meanwhile are ignored; in_ready rises only after the handshake.
REQ-042 reset_n low at round 7 -> all outputs 0 immediately; the next block completes in 35 cycles with round starting at 0.
REQ-043 NUM_ROUNDS=2 and CYC_PER_ROUND=1 -> rnd_en on 2 consecutive cycles, with out_valid the cycle after the second.
